e_md_unit: RTL and testbench

Parametrised multiply/divide unit for the E stage of the five-stage pipeline. It owns the HI/LO registers, runs mult/multu/div/divu with a configurable multi-cycle latency, and executes mthi/mtlo in a single cycle. Its Busy output, together with Start, feeds the hazard unit so that later HI/LO-dependent instructions stall in D.

---
 rtl/md_pkg.sv | 17 +
 rtl/e_md_unit_if.sv | 15 +
 rtl/md_compute.sv | 61 ++++++
 rtl/e_md_unit.sv | 103 ++++++++++
 tb/tb_e_md_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: MDop encodings and the MD unit state enum.
// Also consumed by the Control decoder.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_t;

endpackage

// File: rtl/e_md_unit_if.sv
// E-stage multiply/divide bus: operation request in, Busy and HI/LO out.
interface e_md_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             Start;
    logic [2:0]       MDop;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output Start, MDop, A, B, input Busy, HI, LO);
    modport slave  (input Start, MDop, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath: full-width products and
// truncating division with a divide-by-zero flag.
module md_compute
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mdOp,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divByZero
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] sProd;
    logic        [2*WIDTH-1:0] uProd;
    logic signed [WIDTH-1:0]   sA, sDivisor, sQuot, sRem;
    logic        [WIDTH-1:0]   uDivisor, uQuot, uRem;
    logic                      bZero, sOverflow;

    assign sProd = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uProd = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign bZero     = (b == '0);
    assign sOverflow = (a == MIN_NEG) && (b == '1);

    // Dividing by 1 in the overflow case yields exactly quotient=MIN_NEG, rem=0,
    // and keeps the divider away from zero divisors.
    assign sA       = $signed(a);
    assign sDivisor = (bZero || sOverflow) ? $signed({{(WIDTH-1){1'b0}}, 1'b1}) : $signed(b);
    assign sQuot    = sA / sDivisor;
    assign sRem     = sA % sDivisor;
    assign uDivisor = bZero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign uQuot    = a / uDivisor;
    assign uRem     = a % uDivisor;

    always_comb begin
        hi        = '0;
        lo        = '0;
        divByZero = 1'b0;
        case (mdOp)
            MD_MULT:  {hi, lo} = sProd;
            MD_MULTU: {hi, lo} = uProd;
            MD_DIV: begin
                hi        = sRem;
                lo        = sQuot;
                divByZero = bZero;
            end
            MD_DIVU: begin
                hi        = uRem;
                lo        = uQuot;
                divByZero = bZero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/div with a
// down-counter, and writes mthi/mtlo in a single cycle.
module e_md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    e_md_unit_if.slave  md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdState_t         state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             loadPending, commit, writeHi, writeLo;
    logic [WIDTH-1:0] hiReg, loReg, pendHi, pendLo, compHi, compLo;
    logic             pendDbz, compDbz;

    md_compute #(.WIDTH(WIDTH)) uCompute (
        .a         (md.A),
        .b         (md.B),
        .mdOp      (md.MDop),
        .hi        (compHi),
        .lo        (compLo),
        .divByZero (compDbz)
    );

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        loadPending = 1'b0;
        commit      = 1'b0;
        writeHi     = 1'b0;
        writeLo     = 1'b0;
        case (state)
            IDLE: begin
                if (md.Start) begin
                    case (md.MDop)
                        MD_MULT, MD_MULTU: begin
                            cntNext     = CNT_W'(MULT_CYCLES);
                            stateNext   = RUN;
                            loadPending = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            cntNext     = CNT_W'(DIV_CYCLES);
                            stateNext   = RUN;
                            loadPending = 1'b1;
                        end
                        MD_MTHI: writeHi = 1'b1;
                        MD_MTLO: writeLo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Start is deliberately not looked at here; requests while busy are dropped.
                cntNext = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    stateNext = IDLE;
                    commit    = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            hiReg <= '0;
            loReg <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (commit && !pendDbz) begin
                hiReg <= pendHi;
                loReg <= pendLo;
            end
            if (writeHi) hiReg <= md.A;
            if (writeLo) loReg <= md.A;
        end
    end

    // Pending result is pure data; a reset discards it by leaving RUN.
    always_ff @(posedge Clk) begin
        if (loadPending) begin
            pendHi  <= compHi;
            pendLo  <= compLo;
            pendDbz <= compDbz;
        end
    end

    assign md.Busy = (state == RUN);
    assign md.HI   = hiReg;
    assign md.LO   = loReg;

endmodule

// File: tb/tb_e_md_unit.sv
// Scoreboard bench for e_md_unit: expected HI/LO pushed at issue, popped when Busy falls.
module tb_e_md_unit;
    import md_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] sbQ[$];

    e_md_unit_if #(.WIDTH(32)) md ();

    e_md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .md    (md)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Drives one request for a single edge; returns #1 after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        md.Start = 1'b1; md.MDop = op; md.A = a; md.B = b;
        @(posedge Clk); #1;
        md.Start = 1'b0; md.MDop = 3'd7; md.A = '0; md.B = '0;
    endtask

    // Counts Busy cycles (bounded) and notes any HI/LO movement while busy.
    task automatic countBusy(input logic [31:0] hi0, input logic [31:0] lo0,
                             output int n, output bit changed);
        n = 0; changed = 1'b0;
        while (md.Busy === 1'b1 && n < 64) begin
            if (md.HI !== hi0 || md.LO !== lo0) changed = 1'b1;
            n++;
            @(posedge Clk); #1;
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb;
        longint unsigned ua, ub;
        int q, r;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = {32'd0, a}; ub = {32'd0, b};
        case (op)
            MD_MULT:  return sa * sb;
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 0) return cur;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = int'(sa / sb); r = int'(sa - sb * (sa / sb));
                return {r, q};
            end
            MD_DIVU: begin
                if (b == 0) return cur;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return cur;
        endcase
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (md.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", md.Busy); end
        checks++; if (md.HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", md.HI); end
        checks++; if (md.LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", md.LO); end
        @(negedge Clk); Reset = 1'b0;
    endtask

    task automatic runScoreboarded(input string name, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [63:0] exp, input int expBusy);
        logic [31:0] hi0, lo0;
        logic [63:0] want;
        int n; bit changed;
        hi0 = md.HI; lo0 = md.LO;
        sbQ.push_back(exp);
        issue(op, a, b);
        countBusy(hi0, lo0, n, changed);
        want = sbQ.pop_front();
        checks++; if (n != expBusy) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, n, expBusy); end
        checks++; if (changed) begin errors++; $display("FAIL %s_hold: HI/LO moved while busy, got changed=1 want 0", name); end
        checks++; if ({md.HI, md.LO} !== want) begin errors++; $display("FAIL %s_result: got %h want %h", name, {md.HI, md.LO}, want); end
    endtask

    task automatic test_mult();
        runScoreboarded("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 5);
    endtask

    task automatic test_multu();
        runScoreboarded("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 5);
    endtask

    task automatic test_div();
        runScoreboarded("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10);
    endtask

    task automatic test_divu_zero();
        issue(MD_MTHI, 32'h11, 32'd0);
        checks++; if (md.HI !== 32'h11) begin errors++; $display("FAIL preload_hi: got %h want 11", md.HI); end
        issue(MD_MTLO, 32'h22, 32'd0);
        checks++; if (md.LO !== 32'h22) begin errors++; $display("FAIL preload_lo: got %h want 22", md.LO); end
        runScoreboarded("divu0", MD_DIVU, 32'd100, 32'd0, {32'h11, 32'h22}, 10);
    endtask

    task automatic test_ignore_start();
        logic [31:0] hi0, lo0;
        int n; bit changed;
        hi0 = md.HI; lo0 = md.LO;
        sbQ.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        checks++; if (md.Busy !== 1'b1) begin errors++; $display("FAIL ign_busy_rise: got %b want 1", md.Busy); end
        // mtlo for one edge in the middle of the mult.
        @(negedge Clk);
        md.Start = 1'b1; md.MDop = MD_MTLO; md.A = 32'h1234; md.B = 32'd0;
        @(posedge Clk); #1;
        md.Start = 1'b0; md.MDop = 3'd7; md.A = '0;
        countBusy(hi0, lo0, n, changed);
        checks++; if (n != 4) begin errors++; $display("FAIL ign_remaining_busy: got %0d want 4", n); end
        checks++; if (changed) begin errors++; $display("FAIL ign_hold: HI/LO moved while busy, got changed=1 want 0"); end
        checks++; if ({md.HI, md.LO} !== sbQ.pop_front()) begin errors++; $display("FAIL ign_result: got %h want fffffffffffffffe", {md.HI, md.LO}); end
        issue(MD_MTHI, 32'hABCD, 32'd0);
        checks++; if (md.HI !== 32'hABCD) begin errors++; $display("FAIL mthi_value: got %h want abcd", md.HI); end
        checks++; if (md.Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", md.Busy); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[8];
        logic [31:0] as[8], bs[8];
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_DIV, MD_DIV, MD_MULT, MD_DIVU};
        as  = '{32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7,
                32'h0, 32'h7FFF_FFFF, 32'h0};
        bs  = '{32'h8000_0000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'd16, 32'hFFFF_FFFD,
                32'h0, 32'h7FFF_FFFF, 32'd3};
        for (int i = 0; i < 8; i++) begin
            if (i >= 5) begin as[i] = $urandom; bs[i] = $urandom_range(0, 4) == 0 ? 32'd0 : $urandom; end
            runScoreboarded($sformatf("b2b%0d", i), ops[i], as[i], bs[i],
                            model(ops[i], as[i], bs[i], {md.HI, md.LO}),
                            (ops[i] == MD_MULT || ops[i] == MD_MULTU) ? 5 : 10);
        end
    endtask

    task automatic test_reset_midop();
        bit late;
        issue(MD_MTLO, 32'h5555, 32'd0);
        issue(MD_DIVU, 32'd1000, 32'd7);
        repeat (2) @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;
        checks++; if (md.Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", md.Busy); end
        checks++; if (md.HI !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", md.HI); end
        checks++; if (md.LO !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", md.LO); end
        @(negedge Clk); Reset = 1'b0;
        late = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clk); #1;
            if (md.HI !== 32'd0 || md.LO !== 32'd0 || md.Busy !== 1'b0) late = 1'b1;
        end
        checks++; if (late) begin errors++; $display("FAIL rstmid_no_commit: got HI=%h LO=%h Busy=%b want 0/0/0", md.HI, md.LO, md.Busy); end
    endtask

    initial begin
        md.Start = 1'b0; md.MDop = 3'd7; md.A = '0; md.B = '0;
        Reset = 1'b1;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
